// File: rtl/branch_gen_unit.sv
// Branch generation unit for the dual-issue fetch front end.
// Decodes B/BZ in the fetched pair, picks the next even fetch PC and
// masks wrong-path branches while a redirect is in flight.
// Ports:
//   clk, rst (async, active low), fetch_next_in (advance enable),
//   pc_in, p0_ir_in, p1_ir_in, cond_flag_in
//   -> pc_next_out, ir0_invalid_out, flush_s1_out,
//      branch_taken_out, busy_out
module branch_gen_unit #(
   parameter int PC_W       = 9,
   parameter int IMM_W      = 8,
   parameter int BR_LAT     = 2,
   parameter int SIGNED_OFF = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_next_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic [15:0]     p0_ir_in,
   input  logic [15:0]     p1_ir_in,
   input  logic            cond_flag_in,
   output logic [PC_W-1:0] pc_next_out,
   output logic            ir0_invalid_out,
   output logic            flush_s1_out,
   output logic            branch_taken_out,
   output logic            busy_out
);

   localparam int CNT_W = $clog2(BR_LAT);
   localparam int CH_N  = BR_LAT - 1;

   typedef enum logic {IDLE, SHADOW} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [CH_N-1:0][PC_W-1:0]  chain_q, chain_d;
   logic                       odd_q, odd_d;
   logic                       inv_q, inv_d;

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] tgt0, tgt1, tgt;
   logic            br0, br1, live, p0_tk, p1_tk, taken;
   logic            unused_ir;

   function automatic logic [PC_W-1:0] ext(input logic [IMM_W-1:0] imm);
      if (SIGNED_OFF != 0)
         ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
      else
         ext = {{(PC_W-IMM_W){1'b0}}, imm};
   endfunction

   function automatic logic is_br(input logic [15:0] ir, input logic c);
      is_br = (ir[15:13] == 3'b001) || ((ir[15:13] == 3'b011) && c);
   endfunction

   assign unused_ir = ^{p0_ir_in, p1_ir_in};

   // pc_q is the PC of the pair now in IR: pc_in delayed BR_LAT-1 advances
   assign pc_q = chain_q[CH_N-1];

   always_comb begin
      tgt0  = (pc_q | PC_W'(1)) + ext(p0_ir_in[IMM_W-1:0]);
      tgt1  = (pc_q + PC_W'(2)) + ext(p1_ir_in[IMM_W-1:0]);
      br0   = is_br(p0_ir_in, cond_flag_in);
      br1   = is_br(p1_ir_in, cond_flag_in);
      // detection is live only out of reset, advancing, and not shadowed
      live  = rst && fetch_next_in && (state_q == IDLE);
      p0_tk = live && br0 && !inv_q;
      p1_tk = live && br1;
      taken = p0_tk || p1_tk;
      tgt   = p0_tk ? tgt0 : tgt1;
   end

   always_comb begin
      pc_next_out = pc_in + PC_W'(2);
      unique case (1'b1)
         (rst && !fetch_next_in): pc_next_out = pc_in;
         taken:                   pc_next_out = {tgt[PC_W-1:1], 1'b0};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      odd_d   = odd_q;
      inv_d   = inv_q;
      chain_d = chain_q;
      if (fetch_next_in) begin
         chain_d[0] = pc_in;
         for (int i = 1; i < CH_N; i++)
            chain_d[i] = chain_q[i-1];
         inv_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (taken) begin
                  state_d = SHADOW;
                  cnt_d   = CNT_W'(BR_LAT - 1);
                  odd_d   = tgt[0];
               end
            end
            SHADOW: begin
               if (cnt_q == CNT_W'(1)) begin
                  // target pair arrives next: drop slot 0 if target was odd
                  state_d = IDLE;
                  inv_d   = odd_q;
                  odd_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         chain_q <= '0;
         odd_q   <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chain_q <= chain_d;
         odd_q   <= odd_d;
         inv_q   <= inv_d;
      end
   end

   assign ir0_invalid_out  = inv_q;
   assign flush_s1_out     = (state_q == SHADOW);
   assign busy_out         = (state_q == SHADOW);
   assign branch_taken_out = taken;

endmodule

// File: tb/tb_branch_gen_unit.sv
// Scoreboard bench for branch_gen_unit: instance A uses defaults,
// instance B uses BR_LAT=4 with sign-extended offsets.
module tb_branch_gen_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       fa = 1'b0, ca = 1'b0;
   logic [8:0] pa = '0;
   logic [15:0] a0 = '0, a1 = '0;
   logic [8:0] a_pcn;
   logic       a_inv, a_fl, a_tk, a_bs;

   logic       fb = 1'b0, cb = 1'b0;
   logic [8:0] pb = '0;
   logic [15:0] b0 = '0, b1 = '0;
   logic [8:0] b_pcn;
   logic       b_inv, b_fl, b_tk, b_bs;

   typedef struct {
      bit         b;
      logic [8:0] pc;
      logic       inv, fl, tk, bs;
      string      nm;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_gen_unit u_a (
      .clk(clk), .rst(rst), .fetch_next_in(fa), .pc_in(pa),
      .p0_ir_in(a0), .p1_ir_in(a1), .cond_flag_in(ca),
      .pc_next_out(a_pcn), .ir0_invalid_out(a_inv),
      .flush_s1_out(a_fl), .branch_taken_out(a_tk), .busy_out(a_bs)
   );

   branch_gen_unit #(.BR_LAT(4), .SIGNED_OFF(1)) u_b (
      .clk(clk), .rst(rst), .fetch_next_in(fb), .pc_in(pb),
      .p0_ir_in(b0), .p1_ir_in(b1), .cond_flag_in(cb),
      .pc_next_out(b_pcn), .ir0_invalid_out(b_inv),
      .flush_s1_out(b_fl), .branch_taken_out(b_tk), .busy_out(b_bs)
   );

   task automatic push(input bit b, input logic [8:0] epc,
                       input logic einv, efl, etk, ebs,
                       input string nm);
      exp_t e;
      e.b = b; e.pc = epc; e.inv = einv; e.fl = efl;
      e.tk = etk; e.bs = ebs; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic sa(input logic r, f, input logic [8:0] pc,
                     input logic [15:0] i0, i1, input logic c,
                     input logic [8:0] epc,
                     input logic einv, efl, etk, ebs,
                     input string nm);
      @(posedge clk);
      #1;
      rst = r; fa = f; pa = pc; a0 = i0; a1 = i1; ca = c;
      push(1'b0, epc, einv, efl, etk, ebs, nm);
   endtask

   task automatic sb(input logic f, input logic [8:0] pc,
                     input logic [15:0] i0, i1, input logic c,
                     input logic [8:0] epc,
                     input logic einv, efl, etk, ebs,
                     input string nm);
      @(posedge clk);
      #1;
      fb = f; pb = pc; b0 = i0; b1 = i1; cb = c;
      push(1'b1, epc, einv, efl, etk, ebs, nm);
   endtask

   // monitor: every cycle with a pending expectation is compared
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            exp_t e;
            logic [12:0] got, want;
            e = q.pop_front();
            got = e.b ? {b_pcn, b_inv, b_fl, b_tk, b_bs}
                      : {a_pcn, a_inv, a_fl, a_tk, a_bs};
            want = {e.pc, e.inv, e.fl, e.tk, e.bs};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL %s: got pc=%h inv=%b fl=%b tk=%b bs=%b want pc=%h inv=%b fl=%b tk=%b bs=%b",
                        e.nm, got[12:4], got[3], got[2], got[1], got[0],
                        e.pc, e.inv, e.fl, e.tk, e.bs);
            end
         end
      end
   end

   initial begin
      // reset: branch in IR must be ignored, pc_next = pc_in+2
      sa(0, 1, 9'h010, 16'h2004, 16'h2004, 0, 9'h012, 0, 0, 0, 0, "reset");
      // sequential flow and wrap
      for (int i = 0; i < 4; i++)
         sa(1, 1, 9'(2*i), 16'h0, 16'h0, 0, 9'(2*i+2), 0, 0, 0, 0, "seq");
      sa(1, 1, 9'h1FC, 16'h0, 16'h0, 0, 9'h1FE, 0, 0, 0, 0, "seq_hi");
      sa(1, 1, 9'h1FE, 16'h0, 16'h0, 0, 9'h000, 0, 0, 0, 0, "pc_wrap");
      // p0 B to odd target 0x011
      sa(1, 1, 9'h004, 16'h0, 16'h0, 0, 9'h006, 0, 0, 0, 0, "pre_p0");
      sa(1, 1, 9'h006, 16'h200C, 16'h0, 0, 9'h010, 0, 0, 1, 0, "p0_b_odd");
      sa(1, 1, 9'h010, 16'h2004, 16'h0, 0, 9'h012, 0, 1, 0, 1, "shadow1");
      sa(1, 1, 9'h012, 16'h2004, 16'h0, 0, 9'h014, 1, 0, 0, 0, "inv_p0_masked");
      sa(1, 1, 9'h014, 16'h0, 16'h0, 0, 9'h016, 0, 0, 0, 0, "inv_clear");
      // both slots B: p0 wins, p1 in shadow masked
      sa(1, 1, 9'h020, 16'h0, 16'h0, 0, 9'h022, 0, 0, 0, 0, "pre_both");
      sa(1, 1, 9'h022, 16'h2010, 16'h2040, 0, 9'h030, 0, 0, 1, 0, "both_p0_wins");
      sa(1, 1, 9'h030, 16'h0, 16'h2040, 0, 9'h032, 0, 1, 0, 1, "p1_masked");
      sa(1, 1, 9'h032, 16'h0, 16'h0, 0, 9'h034, 1, 0, 0, 0, "inv_after_both");
      // BZ with flag clear: not taken
      sa(1, 1, 9'h034, 16'h6005, 16'h6005, 0, 9'h036, 0, 0, 0, 0, "bz_not_taken");
      sa(1, 1, 9'h036, 16'h0, 16'h0, 0, 9'h038, 0, 0, 0, 0, "bz_no_flush");
      // p1 B, zero-extended offset 0xF0, even target
      sa(1, 1, 9'h050, 16'h0, 16'h0, 0, 9'h052, 0, 0, 0, 0, "pre_zext");
      sa(1, 1, 9'h052, 16'h0, 16'h20F0, 0, 9'h142, 0, 0, 1, 0, "p1_zext");
      sa(1, 1, 9'h142, 16'h0, 16'h0, 0, 9'h144, 0, 1, 0, 1, "zext_shadow");
      sa(1, 1, 9'h144, 16'h0, 16'h0, 0, 9'h146, 0, 0, 0, 0, "even_no_inv");
      // target arithmetic wraps modulo 2^PC_W
      sa(1, 1, 9'h1FE, 16'h0, 16'h0, 0, 9'h000, 0, 0, 0, 0, "pre_twrap");
      sa(1, 1, 9'h000, 16'h0, 16'h2010, 0, 9'h010, 0, 0, 1, 0, "tgt_wrap");
      sa(1, 1, 9'h010, 16'h0, 16'h0, 0, 9'h012, 0, 1, 0, 1, "twrap_shadow");
      sa(1, 1, 9'h012, 16'h0, 16'h0, 0, 9'h014, 0, 0, 0, 0, "twrap_idle");
      // stall in IDLE with a branch present
      sa(1, 0, 9'h014, 16'h2004, 16'h0, 0, 9'h014, 0, 0, 0, 0, "stall_idle");
      sa(1, 1, 9'h014, 16'h0, 16'h0, 0, 9'h016, 0, 0, 0, 0, "post_stall");
      // async reset one cycle after a branch to odd target
      sa(1, 1, 9'h060, 16'h0, 16'h0, 0, 9'h062, 0, 0, 0, 0, "pre_rst");
      sa(1, 1, 9'h062, 16'h2004, 16'h0, 0, 9'h064, 0, 0, 1, 0, "rst_pre_br");
      sa(0, 1, 9'h064, 16'h0, 16'h0, 0, 9'h066, 0, 0, 0, 0, "async_rst");
      sa(0, 1, 9'h066, 16'h0, 16'h0, 0, 9'h068, 0, 0, 0, 0, "rst_hold");
      sa(1, 1, 9'h070, 16'h0, 16'h0, 0, 9'h072, 0, 0, 0, 0, "no_stale1");
      sa(1, 1, 9'h072, 16'h0, 16'h0, 0, 9'h074, 0, 0, 0, 0, "no_stale2");
      @(posedge clk);
      #1 fa = 1'b0;

      // instance B: BR_LAT=4, signed offsets
      sb(1, 9'h040, 16'h0, 16'h0, 0, 9'h042, 0, 0, 0, 0, "b_fill0");
      sb(1, 9'h042, 16'h0, 16'h0, 0, 9'h044, 0, 0, 0, 0, "b_fill1");
      sb(1, 9'h044, 16'h0, 16'h0, 0, 9'h046, 0, 0, 0, 0, "b_fill2");
      sb(1, 9'h046, 16'h0, 16'h60FE, 1, 9'h040, 0, 0, 1, 0, "bz_signed");
      sb(1, 9'h040, 16'h2004, 16'h0, 0, 9'h042, 0, 1, 0, 1, "b_shadow1");
      for (int i = 0; i < 3; i++)
         sb(0, 9'h042, 16'h2004, 16'h0, 1, 9'h042, 0, 1, 0, 1, "stall_shadow");
      sb(1, 9'h042, 16'h2004, 16'h0, 0, 9'h044, 0, 1, 0, 1, "b_shadow2");
      sb(1, 9'h044, 16'h0, 16'h0, 0, 9'h046, 0, 1, 0, 1, "b_shadow3");
      sb(1, 9'h046, 16'h0, 16'h0, 0, 9'h048, 0, 0, 0, 0, "b_idle");
      sb(1, 9'h048, 16'h20FF, 16'h0, 0, 9'h042, 0, 0, 1, 0, "b_p0_neg");
      sb(1, 9'h042, 16'h0, 16'h0, 0, 9'h044, 0, 1, 0, 1, "b2_shadow");
      @(posedge clk);
      #1 fb = 1'b0;

      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
